// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared definitions for the synchronous FIFO and its burst read controller.
package fifo_rd_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // ceil(log2(v)); clogb2(8) = 3
  function automatic int clogb2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_skid_buf2.sv
// Two-entry in-order output buffer; head entry drives the stream.
module skid_buf2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] e0, e1;

  assign head = e0;

  // Caller guarantees no write when full and no pop when empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e0  <= '0;
      e1  <= '0;
      occ <= 2'd0;
    end else begin
      case ({wr, pop})
        2'b10: begin
          if (occ == 2'd0) e0 <= wr_data;
          else             e1 <= wr_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) e0 <= wr_data;
          else begin
            e0 <= e1;
            e1 <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Burst read controller: pops bursts from a registered-output FIFO into a
// valid/ready stream with a last-beat marker.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int CW    = clogb2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [CW-1:0]    fifo_count,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  input  logic [CW-1:0]    burst_len,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             busy
);

  state_t          state, state_nx;
  logic [CW-1:0]   rd_left, beat_left, eff_len, start_len;
  logic [1:0]      occ;
  logic            inflight, pop, start;

  assign pop     = m_valid && m_ready;
  assign m_valid = (occ != 2'd0);
  assign m_last  = m_valid && (beat_left == CW'(1));
  assign busy    = (state != IDLE);

  always_comb begin
    eff_len = burst_len;
    if (burst_len == '0)              eff_len = CW'(1);
    else if (burst_len > CW'(DEPTH))  eff_len = CW'(DEPTH);
  end

  // A full-length burst wins; flush only takes what is left.
  assign start     = (fifo_count >= eff_len) || (flush && !fifo_empty);
  assign start_len = (fifo_count >= eff_len) ? eff_len : fifo_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = BURST;
      BURST: begin
        // Keep buffered + in-flight words within the 2-entry buffer.
        fifo_rd_en = (rd_left != '0) && !fifo_empty &&
                     (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
        if (pop && beat_left == CW'(1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_left   <= '0;
      beat_left <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (state == IDLE && start) begin
        rd_left   <= start_len;
        beat_left <= start_len;
      end else begin
        if (fifo_rd_en && rd_left != '0)  rd_left   <= rd_left - CW'(1);
        if (pop && beat_left != '0)       beat_left <= beat_left - CW'(1);
      end
    end
  end

  skid_buf2 #(.WIDTH(WIDTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr      (inflight),
    .wr_data (fifo_data),
    .pop     (pop),
    .occ     (occ),
    .head    (m_data)
  );

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a behavioural registered-output FIFO.
module tb_fifo_rd_ctrl;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int CW = 4;

  logic          clk, rst;
  logic          fifo_empty, fifo_rd_en, flush, m_valid, m_ready, m_last, busy;
  logic [CW-1:0] fifo_count, burst_len, spoof_cnt;
  logic [W-1:0]  fifo_data, m_data;
  logic          spoof;

  logic [7:0] fm [0:255];
  int         wp, rp;
  logic [7:0] lg_d [0:63];
  logic       lg_l [0:63];
  int         nl;
  int         mon_err;
  int         total, bad;
  int         s;

  logic       tb_inf, hold_v;
  logic [2:0] tb_occ;
  logic [7:0] hold_d;

  fifo_rd_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .burst_len  (burst_len),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty = (wp == rp);
  assign fifo_count = spoof ? spoof_cnt : CW'(wp - rp);

  initial rp = 0;
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= fm[rp[7:0]];
      rp        <= rp + 1;
    end
  end

  // Reference occupancy model, stall stability and accepted-beat log.
  initial begin
    nl      = 0;
    mon_err = 0;
  end
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tb_inf <= 1'b0;
      tb_occ <= 3'd0;
      hold_v <= 1'b0;
      hold_d <= 8'h00;
    end else begin
      int e;
      e = 0;
      if (fifo_rd_en && fifo_empty)                 e++;
      if ({2'b0, tb_inf} + tb_occ > 3'd2)           e++;
      if (m_valid != (tb_occ != 3'd0))              e++;
      if (hold_v && m_valid && m_data != hold_d)    e++;
      mon_err <= mon_err + e;
      hold_v  <= m_valid && !m_ready;
      hold_d  <= m_data;
      tb_inf  <= fifo_rd_en;
      tb_occ  <= tb_occ + {2'b0, tb_inf} - {2'b0, (m_valid && m_ready)};
      if (m_valid && m_ready) begin
        lg_d[nl[5:0]] <= m_data;
        lg_l[nl[5:0]] <= m_last;
        nl            <= nl + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    fm[wp[7:0]] = d;
    wp++;
  endtask

  task automatic chk_log(input string tag, input int st, input int n,
                         input logic [7:0] base, input logic all_last);
    for (int k = 0; k < n; k++) begin
      chk({tag, "_data"}, 32'(lg_d[(st + k) % 64]), 32'(base + 8'(k)));
      chk({tag, "_last"}, 32'(lg_l[(st + k) % 64]), 32'(all_last || (k == n - 1)));
    end
  endtask

  initial begin
    total = 0; bad = 0; wp = 0;
    spoof = 1'b0; spoof_cnt = '0;
    burst_len = 4'd4; flush = 1'b0; m_ready = 1'b1;
    rst = 1'b1;
    #3 rst = 1'b0;
    #1;
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_last",  32'(m_last), 0);
    chk("rst_data",  32'(m_data), 0);
    @(negedge clk); @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // Full burst of 4 at full rate; trigger cycle is n0.
    push(8'h11); push(8'h12); push(8'h13); push(8'h14);
    #1;
    chk("t1_n0_busy", 32'(busy), 0);
    chk("t1_n0_rd",   32'(fifo_rd_en), 0);
    @(negedge clk); #1;
    chk("t1_n1_busy",  32'(busy), 1);
    chk("t1_n1_rd",    32'(fifo_rd_en), 1);
    chk("t1_n1_valid", 32'(m_valid), 0);
    @(negedge clk); #1;
    chk("t1_n2_rd",    32'(fifo_rd_en), 1);
    chk("t1_n2_valid", 32'(m_valid), 0);
    burst_len = 4'd1;
    @(negedge clk); #1;
    chk("t1_n3_rd",    32'(fifo_rd_en), 1);
    chk("t1_n3_valid", 32'(m_valid), 1);
    chk("t1_n3_data",  32'(m_data), 32'h11);
    chk("t1_n3_last",  32'(m_last), 0);
    @(negedge clk); #1;
    chk("t1_n4_rd",    32'(fifo_rd_en), 1);
    chk("t1_n4_data",  32'(m_data), 32'h12);
    @(negedge clk); #1;
    chk("t1_n5_rd",    32'(fifo_rd_en), 0);
    chk("t1_n5_data",  32'(m_data), 32'h13);
    chk("t1_n5_last",  32'(m_last), 0);
    @(negedge clk); #1;
    chk("t1_n6_data",  32'(m_data), 32'h14);
    chk("t1_n6_last",  32'(m_last), 1);
    @(negedge clk); #1;
    chk("t1_n7_valid", 32'(m_valid), 0);
    chk("t1_n7_busy",  32'(busy), 0);
    burst_len = 4'd4;

    // Backpressure 1,0,0,1,...
    s = nl;
    @(negedge clk);
    push(8'h21); push(8'h22); push(8'h23); push(8'h24);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      m_ready = (i % 4 == 0) || (i % 4 == 3);
    end
    m_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("t2_cnt",  32'(nl - s), 4);
    chk_log("t2", s, 4, 8'h21, 1'b0);
    chk("t2_busy", 32'(busy), 0);

    // Short FIFO waits until flush.
    s = nl;
    @(negedge clk);
    push(8'h31); push(8'h32);
    repeat (6) @(negedge clk);
    #1;
    chk("t3_wait_busy", 32'(busy), 0);
    chk("t3_wait_rd",   32'(fifo_rd_en), 0);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); #1;
    chk("t3_flush_busy", 32'(busy), 1);
    flush = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("t3_cnt", 32'(nl - s), 2);
    chk_log("t3", s, 2, 8'h31, 1'b0);

    // Zero length means single beats.
    s = nl;
    @(negedge clk);
    burst_len = 4'd0;
    push(8'h41); push(8'h42); push(8'h43);
    repeat (20) @(negedge clk);
    #1;
    chk("t4a_cnt", 32'(nl - s), 3);
    chk_log("t4a", s, 3, 8'h41, 1'b1);

    // Oversized length clamps to DEPTH.
    s = nl;
    @(negedge clk);
    burst_len = 4'd15;
    for (int i = 0; i < 8; i++) push(8'h60 + 8'(i));
    @(negedge clk);
    push(8'h68); push(8'h69);
    repeat (20) @(negedge clk);
    #1;
    chk("t4b_cnt",  32'(nl - s), 8);
    chk("t4b_busy", 32'(busy), 0);
    chk_log("t4b", s, 8, 8'h60, 1'b0);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("t4c_cnt", 32'(nl - s), 10);
    chk_log("t4c", s + 8, 2, 8'h68, 1'b0);

    // Reset after two of four beats.
    burst_len = 4'd4;
    s = nl;
    @(negedge clk);
    push(8'h51); push(8'h52); push(8'h53); push(8'h54);
    repeat (5) @(negedge clk);
    #1;
    chk("t5_pre_cnt", 32'(nl - s), 2);
    rst = 1'b0;
    #1;
    chk("t5_valid", 32'(m_valid), 0);
    chk("t5_last",  32'(m_last), 0);
    chk("t5_data",  32'(m_data), 0);
    chk("t5_rd",    32'(fifo_rd_en), 0);
    chk("t5_busy",  32'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("t5_post_valid", 32'(m_valid), 0);
    chk("t5_post_busy",  32'(busy), 0);
    s = nl;
    push(8'h71); push(8'h72); push(8'h73); push(8'h74);
    repeat (12) @(negedge clk);
    #1;
    chk("t5_cnt", 32'(nl - s), 4);
    chk_log("t5", s, 4, 8'h71, 1'b0);

    // FIFO runs dry mid-burst.
    s = nl;
    @(negedge clk);
    spoof = 1'b1; spoof_cnt = 4'd4;
    push(8'h81); push(8'h82);
    @(negedge clk);
    spoof = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("t6_dry_busy",  32'(busy), 1);
    chk("t6_dry_rd",    32'(fifo_rd_en), 0);
    chk("t6_dry_valid", 32'(m_valid), 0);
    chk("t6_dry_cnt",   32'(nl - s), 2);
    push(8'h83); push(8'h84);
    repeat (10) @(negedge clk);
    #1;
    chk("t6_cnt",  32'(nl - s), 4);
    chk("t6_busy", 32'(busy), 0);
    chk_log("t6", s, 4, 8'h81, 1'b0);

    chk("monitor", 32'(mon_err), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
